tridiag_det_loader: RTL

Upstream sequencer for tridiag_det_core. It accepts the matrix as a valid/ready stream of WIDTH-bit words and writes them over the core's register bus. It then starts the core, polls the done status, reads the 32-bit determinant and acks the core. The result is returned on a valid/ready output stream with a completion-cycle count and a slow-completion flag.

---
 rtl/tridiag_det_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tridiag_det_loader.sv
// Streams a tridiagonal matrix into tridiag_det_core over its register bus, runs it,
// and returns the determinant with a poll-cycle count on a valid/ready result stream.
module tridiag_det_loader #(
  parameter int N       = 16,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             bus_we,
  output logic [7:0]       bus_address,
  output logic [16:0]      bus_write_data,
  input  logic [31:0]      bus_read_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_det,
  output logic [15:0]      out_cycles,
  output logic             out_err,
  output logic             busy
);

  localparam int NW = 3*N - 2;
  localparam int CW = $clog2(NW);

  typedef enum logic [2:0] {LOAD, START, POLL, RDET, ACK, OUT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] word_cnt, word_cnt_nx;
  logic [15:0]   poll_cnt, poll_cnt_nx;
  logic          bus_we_nx;
  logic [7:0]    bus_addr_nx;
  logic [16:0]   bus_wdata_nx;
  logic [31:0]   out_det_nx;
  logic [15:0]   out_cycles_nx;
  logic          out_err_nx;
  logic [7:0]    word_addr;
  logic          in_hs, done_seen;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUT);
  assign busy      = (state != LOAD);
  assign in_hs     = in_valid & in_ready;
  // The status bit is only trusted once the poll address is actually on the bus.
  assign done_seen = (bus_address == 8'h01) & ~bus_we & bus_read_data[0];

  // Words arrive as a[0..N-2], b[0..N-1], c[0..N-2]; each band has its own page.
  always_comb begin
    if (word_cnt < CW'(N-1))
      word_addr = 8'h10 + 8'(word_cnt);
    else if (word_cnt < CW'(2*N-1))
      word_addr = 8'h20 + 8'(word_cnt - CW'(N-1));
    else
      word_addr = 8'h30 + 8'(word_cnt - CW'(2*N-1));
  end

  always_comb begin
    state_nx      = state;
    word_cnt_nx   = word_cnt;
    poll_cnt_nx   = poll_cnt;
    bus_we_nx     = 1'b0;
    bus_addr_nx   = bus_address;
    bus_wdata_nx  = bus_write_data;
    out_det_nx    = out_det;
    out_cycles_nx = out_cycles;
    out_err_nx    = out_err;
    unique case (state)
      LOAD: begin
        if (in_hs) begin
          bus_we_nx    = 1'b1;
          bus_addr_nx  = word_addr;
          bus_wdata_nx = 17'(in_data);
          word_cnt_nx  = word_cnt + CW'(1);
          if (word_cnt == CW'(NW-1)) state_nx = START;
        end
      end
      START: begin
        bus_we_nx    = 1'b1;
        bus_addr_nx  = 8'h00;
        bus_wdata_nx = 17'h1;
        poll_cnt_nx  = 16'h0;
        state_nx     = POLL;
      end
      POLL: begin
        bus_addr_nx = 8'h01;
        if (poll_cnt != 16'hFFFF) poll_cnt_nx = poll_cnt + 16'd1;
        // Present the result address early so it is on the bus during RDET.
        if (done_seen) begin
          bus_addr_nx = 8'h40;
          state_nx    = RDET;
        end
      end
      RDET: begin
        out_det_nx = bus_read_data;
        state_nx   = ACK;
      end
      ACK: begin
        bus_we_nx     = 1'b1;
        bus_addr_nx   = 8'h02;
        bus_wdata_nx  = 17'h0;
        out_cycles_nx = poll_cnt;
        out_err_nx    = (poll_cnt > 16'(TIMEOUT));
        state_nx      = OUT;
      end
      OUT: begin
        if (out_ready) begin
          word_cnt_nx = '0;
          state_nx    = LOAD;
        end
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LOAD;
      word_cnt       <= '0;
      poll_cnt       <= '0;
      bus_we         <= 1'b0;
      bus_address    <= '0;
      bus_write_data <= '0;
      out_det        <= '0;
      out_cycles     <= '0;
      out_err        <= 1'b0;
    end else begin
      state          <= state_nx;
      word_cnt       <= word_cnt_nx;
      poll_cnt       <= poll_cnt_nx;
      bus_we         <= bus_we_nx;
      bus_address    <= bus_addr_nx;
      bus_write_data <= bus_wdata_nx;
      out_det        <= out_det_nx;
      out_cycles     <= out_cycles_nx;
      out_err        <= out_err_nx;
    end
  end

endmodule
